// File: rtl/jr_redirect_unit_pkg.sv
// Shared types and constants for the JR redirect unit and its source mux.
package jr_redirect_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_REDIRECT  = 2'd2
  } jr_state_e;

  localparam int unsigned R0_IDX      = 0;
  localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/jr_redirect_unit_src_mux.sv
// Fixed-priority select of the JR target source; R0 always reads as zero.
module jr_src_mux
  import jr_redirect_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4
) (
  input  logic [REG_W-1:0]  jr_reg,
  input  logic              fwd_ex,
  input  logic              fwd_mem,
  input  logic              fwd_mem_ldata,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  output logic [DATA_W-1:0] jr_target
);

  always_comb begin
    jr_target = rf_data;
    if (jr_reg == REG_W'(R0_IDX)) begin
      jr_target = '0;
    end else if (fwd_ex) begin
      jr_target = ex_alu_result;
    end else if (fwd_mem_ldata) begin
      jr_target = mem_load_data;
    end else if (fwd_mem) begin
      jr_target = mem_alu_result;
    end
  end

endmodule

// File: rtl/jr_redirect_unit.sv
// JR target capture, load-use stall and held PC redirect toward fetch.
module jr_redirect_unit
  import jr_redirect_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_is_jr,
  input  logic [REG_W-1:0]       id_jr_reg,
  input  logic                   fwd_ex,
  input  logic                   fwd_mem,
  input  logic                   fwd_mem_ldata,
  input  logic                   fwd_id,
  input  logic [REG_W-1:0]       ex_dst,
  input  logic                   ex_we,
  input  logic                   ex_mem_re,
  input  logic [DATA_W-1:0]      id_rf_data,
  input  logic [DATA_W-1:0]      ex_alu_result,
  input  logic [DATA_W-1:0]      mem_alu_result,
  input  logic [DATA_W-1:0]      mem_load_data,
  input  logic                   fetch_ack,
  output logic                   stall_if_id,
  output logic                   redirect_valid,
  output logic [DATA_W-1:0]      redirect_target,
  output logic                   flush_if,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  jr_state_e               state_q, state_d;
  logic                    hz;
  logic                    stall_c;
  logic                    capture;
  logic [DATA_W-1:0]       sel_target;
  logic [DATA_W-1:0]       target_q;
  logic [STALL_CNT_W-1:0]  cnt_q;
  logic                    unused_fwd_id;

  // No select active already falls through to the register-file read.
  assign unused_fwd_id = fwd_id;

  assign hz = id_is_jr & ex_mem_re & ex_we & (ex_dst == id_jr_reg) &
              (id_jr_reg != REG_W'(R0_IDX));

  jr_src_mux #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_src_mux (
    .jr_reg         (id_jr_reg),
    .fwd_ex         (fwd_ex),
    .fwd_mem        (fwd_mem),
    .fwd_mem_ldata  (fwd_mem_ldata),
    .rf_data        (id_rf_data),
    .ex_alu_result  (ex_alu_result),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .jr_target      (sel_target)
  );

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (id_is_jr) begin
          if (hz) begin
            stall_c = 1'b1;
            state_d = ST_LOAD_WAIT;
          end else begin
            capture = 1'b1;
            state_d = ST_REDIRECT;
          end
        end
      end
      ST_LOAD_WAIT: begin
        stall_c = 1'b1;
        capture = 1'b1;
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        stall_c = 1'b1;
        if (fetch_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (capture) target_q <= sel_target;
      if (stall_c && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Gated by rst_n so the combinational IDLE stall also clears during reset.
  assign stall_if_id     = stall_c & rst_n;
  assign redirect_valid  = (state_q == ST_REDIRECT);
  assign flush_if        = (state_q == ST_REDIRECT);
  assign redirect_target = target_q;
  assign stall_cycles    = cnt_q;

endmodule

// File: tb/tb_jr_redirect_unit.sv
// Directed bench for jr_redirect_unit with a transaction-level reference model.
module tb_jr_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_is_jr;
  logic [3:0]  id_jr_reg;
  logic        fwd_ex, fwd_mem, fwd_mem_ldata, fwd_id;
  logic [3:0]  ex_dst;
  logic        ex_we, ex_mem_re;
  logic [15:0] id_rf_data, ex_alu_result, mem_alu_result, mem_load_data;
  logic        fetch_ack;
  logic        stall_if_id, redirect_valid, flush_if;
  logic [15:0] redirect_target, stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jr_redirect_unit #(.DATA_W(16), .REG_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_is_jr        (id_is_jr),
    .id_jr_reg       (id_jr_reg),
    .fwd_ex          (fwd_ex),
    .fwd_mem         (fwd_mem),
    .fwd_mem_ldata   (fwd_mem_ldata),
    .fwd_id          (fwd_id),
    .ex_dst          (ex_dst),
    .ex_we           (ex_we),
    .ex_mem_re       (ex_mem_re),
    .id_rf_data      (id_rf_data),
    .ex_alu_result   (ex_alu_result),
    .mem_alu_result  (mem_alu_result),
    .mem_load_data   (mem_load_data),
    .fetch_ack       (fetch_ack),
    .stall_if_id     (stall_if_id),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .flush_if        (flush_if),
    .stall_cycles    (stall_cycles)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a JR either owes one load-wait cycle or a redirect is pending.
  bit          m_owe_wait;
  bit          m_pending;
  logic [15:0] m_target;
  int          m_stalls;

  function automatic logic [15:0] pick_src();
    if (id_jr_reg == 4'd0) return 16'h0000;
    if (fwd_ex)            return ex_alu_result;
    if (fwd_mem_ldata)     return mem_load_data;
    if (fwd_mem)           return mem_alu_result;
    return id_rf_data;
  endfunction

  function automatic bit load_use();
    return id_is_jr && ex_mem_re && ex_we && (ex_dst == id_jr_reg) && (id_jr_reg != 4'd0);
  endfunction

  function automatic bit busy();
    return m_owe_wait || m_pending;
  endfunction

  function automatic bit exp_stall();
    return rst_n && (busy() || load_use());
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owe_wait <= 1'b0;
      m_pending  <= 1'b0;
      m_target   <= 16'h0;
      m_stalls   <= 0;
    end else begin
      if (exp_stall() && m_stalls < 65535) m_stalls <= m_stalls + 1;
      if (m_pending) begin
        if (fetch_ack) m_pending <= 1'b0;
      end else if (m_owe_wait) begin
        m_owe_wait <= 1'b0;
        m_pending  <= 1'b1;
        m_target   <= pick_src();
      end else if (id_is_jr) begin
        if (load_use()) m_owe_wait <= 1'b1;
        else begin
          m_pending <= 1'b1;
          m_target  <= pick_src();
        end
      end
    end
  end

  always @(negedge clk) begin
    check("stall_if_id", 32'(stall_if_id), 32'(exp_stall()));
    check("redirect_valid", 32'(redirect_valid), 32'(m_pending));
    check("flush_if", 32'(flush_if), 32'(m_pending));
    check("redirect_target", 32'(redirect_target), 32'(m_target));
    check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_is_jr = 0; id_jr_reg = 0; fwd_ex = 0; fwd_mem = 0; fwd_mem_ldata = 0; fwd_id = 0;
    ex_dst = 0; ex_we = 0; ex_mem_re = 0; id_rf_data = 0; ex_alu_result = 0;
    mem_alu_result = 0; mem_load_data = 0; fetch_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_in();
    @(negedge clk);
    check("rst_valid", 32'(redirect_valid), 32'h0);
    check("rst_cnt", 32'(stall_cycles), 32'h0);
    tick();
    rst_n = 1'b1;

    // Idle noise: no JR, hazard-looking EX fields
    ex_mem_re = 1; ex_we = 1; ex_dst = 4'd3; id_jr_reg = 4'd3;
    repeat (2) tick();
    clear_in();

    // JR R3 from register file, ack on first redirect cycle
    id_is_jr = 1; id_jr_reg = 4'd3; fwd_id = 1; id_rf_data = 16'h0040;
    @(negedge clk);
    check("jr3_no_stall", 32'(stall_if_id), 32'h0);
    tick();
    clear_in(); fetch_ack = 1;
    @(negedge clk);
    check("jr3_valid", 32'(redirect_valid), 32'h1);
    check("jr3_target", 32'(redirect_target), 32'h0040);
    tick();
    fetch_ack = 0;
    @(negedge clk);
    check("jr3_valid_drop", 32'(redirect_valid), 32'h0);
    check("jr3_cnt", 32'(stall_cycles), 32'h1);

    // JR R5, EX beats MEM
    id_is_jr = 1; id_jr_reg = 4'd5; fwd_ex = 1; fwd_mem = 1;
    ex_alu_result = 16'h1234; mem_alu_result = 16'h5678;
    tick();
    clear_in(); fetch_ack = 1;
    @(negedge clk);
    check("jr5_target", 32'(redirect_target), 32'h1234);
    tick();
    clear_in();

    // JR R7 load-use: one wait cycle, then load data
    id_is_jr = 1; id_jr_reg = 4'd7; ex_mem_re = 1; ex_we = 1; ex_dst = 4'd7;
    @(negedge clk);
    check("jr7_stall_idle", 32'(stall_if_id), 32'h1);
    tick();
    ex_mem_re = 0; ex_we = 0; ex_dst = 0; fwd_mem_ldata = 1; mem_load_data = 16'hBEEF;
    @(negedge clk);
    check("jr7_wait_valid", 32'(redirect_valid), 32'h0);
    check("jr7_wait_stall", 32'(stall_if_id), 32'h1);
    tick();
    clear_in(); fetch_ack = 1;
    @(negedge clk);
    check("jr7_valid", 32'(redirect_valid), 32'h1);
    check("jr7_target", 32'(redirect_target), 32'hBEEF);
    tick();
    clear_in();

    // JR R0: never a hazard, target forced to zero
    id_is_jr = 1; id_jr_reg = 4'd0; fwd_ex = 1; ex_alu_result = 16'hFFFF;
    ex_mem_re = 1; ex_we = 1; ex_dst = 4'd0;
    @(negedge clk);
    check("jr0_no_stall", 32'(stall_if_id), 32'h0);
    tick();
    clear_in(); fetch_ack = 1;
    @(negedge clk);
    check("jr0_valid", 32'(redirect_valid), 32'h1);
    check("jr0_target", 32'(redirect_target), 32'h0000);
    tick();
    clear_in();

    // JR R2, load data beats MEM ALU; fetch holds off 5 cycles
    id_is_jr = 1; id_jr_reg = 4'd2; fwd_mem = 1; fwd_mem_ldata = 1;
    mem_alu_result = 16'h2222; mem_load_data = 16'h3333;
    tick();
    id_jr_reg = 4'd6; id_rf_data = 16'h6666; fwd_mem = 0; fwd_mem_ldata = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_target", 32'(redirect_target), 32'h3333);
      check("hold_flush", 32'(flush_if), 32'h1);
      tick();
    end
    clear_in(); fetch_ack = 1;
    tick();
    fetch_ack = 0;
    @(negedge clk);
    check("hold_released", 32'(redirect_valid), 32'h0);

    // Reset during LOAD_WAIT
    id_is_jr = 1; id_jr_reg = 4'd9; ex_mem_re = 1; ex_we = 1; ex_dst = 4'd9;
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_stall", 32'(stall_if_id), 32'h0);
    check("arst_valid", 32'(redirect_valid), 32'h0);
    check("arst_cnt", 32'(stall_cycles), 32'h0);
    check("arst_target", 32'(redirect_target), 32'h0);
    tick();
    clear_in();
    rst_n = 1'b1;
    tick();
    id_is_jr = 1; id_jr_reg = 4'd4; id_rf_data = 16'h0ABC;
    tick();
    clear_in(); fetch_ack = 1;
    @(negedge clk);
    check("post_rst_target", 32'(redirect_target), 32'h0ABC);
    check("post_rst_cnt", 32'(stall_cycles), 32'h0);
    tick();
    clear_in();
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
